// File: rtl/comp_strg_sched_if.sv
// Bundles the requester, response and storage-port signals of comp_strg_sched.
// The slave modport is the scheduler's view; master is the surrounding environment.
`ifndef STRG_ADDRESS_WIDTH
`define STRG_ADDRESS_WIDTH 8
`endif
`ifndef STRG_DATA_WIDTH
`define STRG_DATA_WIDTH 16
`endif

interface comp_strg_sched_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = `STRG_ADDRESS_WIDTH,
  parameter int unsigned DATA_W  = `STRG_DATA_WIDTH
);
  localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // requester side
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [2*NUM_REQ-1:0]      req_cmd;
  logic [ADDR_W*NUM_REQ-1:0] req_addA;
  logic [ADDR_W*NUM_REQ-1:0] req_addB;
  logic [ADDR_W*NUM_REQ-1:0] req_addC;
  logic [DATA_W*NUM_REQ-1:0] req_data;
  // response side
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [IDW-1:0]            rsp_id;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_err;
  // storage port
  logic                      strg_en;
  logic [1:0]                strg_cmd;
  logic [ADDR_W-1:0]         strg_addA;
  logic [ADDR_W-1:0]         strg_addB;
  logic [ADDR_W-1:0]         strg_addC;
  logic [DATA_W-1:0]         strg_dq_out;
  logic                      strg_dq_oe;
  logic [DATA_W-1:0]         strg_dq_in;
  logic                      strg_valid;

  modport slave (
    input  req_valid, req_cmd, req_addA, req_addB, req_addC, req_data,
           rsp_ready, strg_dq_in, strg_valid,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
           strg_en, strg_cmd, strg_addA, strg_addB, strg_addC,
           strg_dq_out, strg_dq_oe
  );

  modport master (
    output req_valid, req_cmd, req_addA, req_addB, req_addC, req_data,
           rsp_ready, strg_dq_in, strg_valid,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
           strg_en, strg_cmd, strg_addA, strg_addB, strg_addC,
           strg_dq_out, strg_dq_oe
  );
endinterface

// File: rtl/comp_strg_sched.sv
// Round-robin scheduler sharing one computation-storage block among NUM_REQ
// requesters. One command outstanding at a time: accept, issue, wait for
// valid_out (or time out), then return the tagged response.
`ifndef STRG_ADDRESS_WIDTH
`define STRG_ADDRESS_WIDTH 8
`endif
`ifndef STRG_DATA_WIDTH
`define STRG_DATA_WIDTH 16
`endif

module comp_strg_sched #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = `STRG_ADDRESS_WIDTH,
  parameter int unsigned DATA_W  = `STRG_DATA_WIDTH,
  parameter int unsigned TIMEOUT = 16
) (
  input logic clk,
  input logic rst,
  comp_strg_sched_if.slave bus
);
  localparam int unsigned   IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned   CNTW   = $clog2(TIMEOUT + 1);
  localparam logic [IDW:0]  NREQ_L = (IDW+1)'(NUM_REQ);
  localparam logic [CNTW-1:0] TO_L = CNTW'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            r_state, w_next;
  logic [IDW-1:0]    r_ptr, r_id;
  logic [1:0]        r_cmd;
  logic [ADDR_W-1:0] r_addA, r_addB, r_addC;
  logic [DATA_W-1:0] r_data, r_rsp_data;
  logic              r_rsp_err;
  logic [CNTW-1:0]   r_cnt;

  logic              w_found;
  logic [IDW-1:0]    w_grant, w_ptr_nxt;
  logic [IDW:0]      w_sum;
  logic [NUM_REQ-1:0] w_ready;
  logic [1:0]        w_cmd;
  logic [ADDR_W-1:0] w_addA, w_addB, w_addC;
  logic [DATA_W-1:0] w_data;

  // Round-robin search from r_ptr upward with wrap, plus mux of the granted slice
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_sum   = '0;
    w_ready = '0;
    w_cmd   = '0;
    w_addA  = '0;
    w_addB  = '0;
    w_addC  = '0;
    w_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, r_ptr} + (IDW+1)'(i);
      if (w_sum >= NREQ_L) w_sum = w_sum - NREQ_L;
      if (!w_found && bus.req_valid[w_sum[IDW-1:0]]) begin
        w_found = 1'b1;
        w_grant = w_sum[IDW-1:0];
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_grant == IDW'(i)) begin
        w_cmd  = bus.req_cmd[2*i +: 2];
        w_addA = bus.req_addA[ADDR_W*i +: ADDR_W];
        w_addB = bus.req_addB[ADDR_W*i +: ADDR_W];
        w_addC = bus.req_addC[ADDR_W*i +: ADDR_W];
        w_data = bus.req_data[DATA_W*i +: DATA_W];
        w_ready[i] = (r_state == S_IDLE) && w_found;
      end
    end
    w_ptr_nxt = (w_grant == IDW'(NUM_REQ - 1)) ? '0 : w_grant + 1'b1;
  end

  assign bus.req_ready = w_ready;
  assign bus.strg_cmd  = r_cmd;
  assign bus.strg_addA = r_addA;
  assign bus.strg_addB = r_addB;
  assign bus.strg_addC = r_addC;
  assign bus.rsp_id    = r_id;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_err   = r_rsp_err;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state decode and per-state storage/response strobes
  always_comb begin
    w_next          = r_state;
    bus.strg_en     = 1'b0;
    bus.strg_dq_oe  = 1'b0;
    bus.strg_dq_out = '0;
    bus.rsp_valid   = 1'b0;
    case (r_state)
      S_IDLE:  if (w_found) w_next = S_ISSUE;
      S_ISSUE: begin
        bus.strg_en = 1'b1;
        if (r_cmd == 2'b00) begin
          bus.strg_dq_oe  = 1'b1;
          bus.strg_dq_out = r_data;
        end
        w_next = S_WAIT;
      end
      S_WAIT:  if (bus.strg_valid || (r_cnt == TO_L)) w_next = S_RESP;
      S_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Command latch, rr pointer, wait counter and response capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr      <= '0;
      r_id       <= '0;
      r_cmd      <= '0;
      r_addA     <= '0;
      r_addB     <= '0;
      r_addC     <= '0;
      r_data     <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_found) begin
          r_id   <= w_grant;
          r_cmd  <= w_cmd;
          r_addA <= w_addA;
          r_addB <= w_addB;
          r_addC <= w_addC;
          r_data <= w_data;
          r_ptr  <= w_ptr_nxt;
        end
        S_ISSUE: r_cnt <= CNTW'(1);
        S_WAIT: begin
          // a valid on the final counted cycle still wins over the timeout
          if (bus.strg_valid) begin
            r_rsp_data <= bus.strg_dq_in;
            r_rsp_err  <= 1'b0;
          end else if (r_cnt == TO_L) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_comp_strg_sched.sv
// Self-checking bench for comp_strg_sched: directed scenarios followed by
// randomized traffic, checked against a transaction-level reference model.
module tb_comp_strg_sched;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  comp_strg_sched_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  comp_strg_sched #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // reference model state: per-requester pending commands and rr pointer
  logic [1:0]    mc [N];
  logic [AW-1:0] ma [N];
  logic [AW-1:0] mb [N];
  logic [AW-1:0] mcc[N];
  logic [DW-1:0] md [N];
  logic [N-1:0]  pend = '0;
  int            mdl_ptr = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_reqs();
    for (int r = 0; r < N; r++) begin
      bus.req_cmd[r*2 +: 2]    = mc[r];
      bus.req_addA[r*AW +: AW] = ma[r];
      bus.req_addB[r*AW +: AW] = mb[r];
      bus.req_addC[r*AW +: AW] = mcc[r];
      bus.req_data[r*DW +: DW] = md[r];
    end
    bus.req_valid = pend;
  endtask

  task automatic post(input int r, input logic [1:0] c);
    mc[r]  = c;
    ma[r]  = AW'($urandom);
    mb[r]  = AW'($urandom);
    mcc[r] = AW'($urandom);
    md[r]  = DW'($urandom);
    pend[r] = 1'b1;
  endtask

  // first pending requester at or after the pointer, wrapping around
  function automatic int exp_grant();
    for (int k = 0; k < N; k++)
      if (pend[(mdl_ptr + k) % N]) return (mdl_ptr + k) % N;
    return -1;
  endfunction

  // One full transaction from IDLE. vd = WAIT cycle carrying strg_valid
  // (outside 1..TO means never), hold = cycles rsp_ready stays low.
  task automatic run_txn(input int vd, input int hold, input logic [DW-1:0] dqv);
    int g;
    logic [N-1:0]  onehot;
    logic [DW-1:0] exp_d;
    logic          exp_e;
    drive_reqs();
    #1;
    g = exp_grant();
    onehot = '0;
    if (g >= 0) onehot[g] = 1'b1;
    check("idle_req_ready", bus.req_ready, onehot);
    check("idle_rsp_valid", bus.rsp_valid, 0);
    check("idle_strg_en", bus.strg_en, 0);
    if (g < 0) return;
    @(posedge clk); #1;
    pend[g] = 1'b0;
    bus.req_valid  = pend;
    bus.strg_valid = 1'($urandom_range(0, 1));
    bus.strg_dq_in = DW'($urandom);
    mdl_ptr = (g + 1) % N;
    #1;
    check("issue_en", bus.strg_en, 1);
    check("issue_cmd", bus.strg_cmd, mc[g]);
    check("issue_addA", bus.strg_addA, ma[g]);
    check("issue_addB", bus.strg_addB, mb[g]);
    check("issue_addC", bus.strg_addC, mcc[g]);
    check("issue_oe", bus.strg_dq_oe, (mc[g] == 2'b00));
    check("issue_dq_out", bus.strg_dq_out, (mc[g] == 2'b00) ? md[g] : '0);
    check("issue_req_ready", bus.req_ready, 0);
    for (int k = 1; k <= TO; k++) begin
      @(posedge clk); #1;
      check("wait_en", bus.strg_en, 0);
      check("wait_oe", bus.strg_dq_oe, 0);
      check("wait_rsp_valid", bus.rsp_valid, 0);
      check("wait_cmd_held", bus.strg_cmd, mc[g]);
      bus.strg_valid = (k == vd);
      bus.strg_dq_in = (k == vd) ? dqv : DW'($urandom);
      if (k == vd) break;
    end
    exp_e = !(vd >= 1 && vd <= TO);
    exp_d = exp_e ? '0 : dqv;
    @(posedge clk); #1;
    bus.strg_valid = 1'b1;
    bus.strg_dq_in = DW'($urandom);
    bus.rsp_ready  = (hold == 0);
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) begin
        @(posedge clk); #1;
        bus.rsp_ready = (h == hold);
      end
      #1;
      check("rsp_valid", bus.rsp_valid, 1);
      check("rsp_id", bus.rsp_id, g);
      check("rsp_data", bus.rsp_data, exp_d);
      check("rsp_err", bus.rsp_err, exp_e);
      check("rsp_req_ready", bus.req_ready, 0);
      check("rsp_strg_en", bus.strg_en, 0);
    end
    @(posedge clk); #1;
    bus.rsp_ready  = 1'b0;
    bus.strg_valid = 1'b0;
    check("post_rsp_valid", bus.rsp_valid, 0);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_req_ready"}, bus.req_ready, 0);
    check({pfx, "_rsp_valid"}, bus.rsp_valid, 0);
    check({pfx, "_rsp_id"}, bus.rsp_id, 0);
    check({pfx, "_rsp_data"}, bus.rsp_data, 0);
    check({pfx, "_rsp_err"}, bus.rsp_err, 0);
    check({pfx, "_strg_en"}, bus.strg_en, 0);
    check({pfx, "_strg_cmd"}, bus.strg_cmd, 0);
    check({pfx, "_strg_addC"}, bus.strg_addC, 0);
    check({pfx, "_strg_oe"}, bus.strg_dq_oe, 0);
    check({pfx, "_strg_dq_out"}, bus.strg_dq_out, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] nb;
    for (int r = 0; r < N; r++) begin
      mc[r] = '0; ma[r] = '0; mb[r] = '0; mcc[r] = '0; md[r] = '0;
    end
    bus.rsp_ready  = 1'b0;
    bus.strg_valid = 1'b0;
    bus.strg_dq_in = '0;
    drive_reqs();

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // all four requesters at once: grants 0,1,2,3 in order
    for (int r = 0; r < N; r++) post(r, 2'($urandom));
    for (int r = 0; r < N; r++) run_txn($urandom_range(1, 3), 0, DW'($urandom));

    // req0 WRITE addC=3 data=0xA5, valid two cycles after en
    post(0, 2'b00);
    mcc[0] = 8'h03;
    md[0]  = 16'h00A5;
    run_txn(2, 0, 16'h5A5A);

    // req1 READ returning 0x1234 on the first WAIT cycle (minimum latency)
    post(1, 2'b01);
    run_txn(1, 0, 16'h1234);

    // req2 ADD with no valid_out: timeout, then a normal transaction
    post(2, 2'b10);
    run_txn(0, 0, 16'hFFFF);
    post(3, 2'b11);
    run_txn(4, 0, 16'hBEEF);

    // valid exactly on the TIMEOUT cycle counts as success
    post(1, 2'b10);
    run_txn(TO, 0, 16'hC0DE);

    // response back-pressured 5 cycles with another requester pending
    post(3, 2'b01);
    post(0, 2'b11);
    run_txn(2, 5, 16'h7777);
    run_txn(1, 0, 16'h8888);

    // reset during WAIT, stray valid pulses afterwards
    post(1, 2'b01);
    drive_reqs();
    @(posedge clk); #1;
    pend = '0;
    bus.req_valid = pend;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_all_zero("midreset");
    mdl_ptr = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    bus.strg_valid = 1'b1;
    bus.strg_dq_in = 16'hDEAD;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("stray_rsp_valid", bus.rsp_valid, 0);
      check("stray_strg_en", bus.strg_en, 0);
    end
    bus.strg_valid = 1'b0;
    for (int r = 0; r < N; r++) post(r, 2'($urandom));
    run_txn(1, 0, 16'h0F0F);

    // randomized traffic
    for (int t = 0; t < 30; t++) begin
      nb = N'($urandom);
      for (int r = 0; r < N; r++)
        if (nb[r] && !pend[r]) post(r, 2'($urandom));
      if (pend == '0) post($urandom_range(0, N - 1), 2'($urandom));
      run_txn($urandom_range(0, TO + 2), $urandom_range(0, 3), DW'($urandom));
    end
    while (pend != '0) run_txn($urandom_range(1, TO), 0, DW'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
